// File: rtl/inst_sram.sv
// inst_sram: single-port instruction memory with registered read, error flag and access counters
module inst_sram #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_sram_en,
  input  logic             inst_sram_wen,
  input  logic [31:0]      inst_sram_addr,
  input  logic [31:0]      inst_sram_write_data,
  output logic [31:0]      inst_sram_read_data,
  output logic             inst_sram_rvalid,
  output logic             addr_err,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt
);
  logic [31:0] mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic legal, rd, rd_ok, wr_ok;
  assign idx   = inst_sram_addr[ADDR_W+1:2];
  assign legal = (inst_sram_addr[1:0] == 2'b00) && (inst_sram_addr[31:ADDR_W+2] == '0);
  assign rd    = inst_sram_en & ~inst_sram_wen;
  assign rd_ok = rd & legal;
  assign wr_ok = inst_sram_en & inst_sram_wen & legal;
  // array write port; contents survive reset
  always_ff @(posedge clk)
    if (wr_ok) mem[idx] <= inst_sram_write_data;
  // registered read data, valid strobe, sticky error and counters
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      inst_sram_read_data <= '0;
      inst_sram_rvalid    <= 1'b0;
      addr_err            <= 1'b0;
      rd_cnt              <= '0;
      wr_cnt              <= '0;
    end else begin
      inst_sram_rvalid <= rd;
      if (rd) inst_sram_read_data <= legal ? mem[idx] : '0;
      if (inst_sram_en && !legal) addr_err <= 1'b1;
      if (rd_ok) rd_cnt <= rd_cnt + CNT_W'(1);
      if (wr_ok) wr_cnt <= wr_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_inst_sram.sv
// tb_inst_sram: directed bench with a read-data scoreboard for inst_sram
module tb_inst_sram;
  localparam int DEPTH = 1024;
  logic clk = 0, rst = 0, en = 0, wen = 0;
  logic [31:0] addr = 0, wdata = 0, rdata;
  logic rvalid, err;
  logic [31:0] rd_cnt, wr_cnt;
  int checks = 0, errors = 0;
  logic [31:0] q [$];
  logic [31:0] mdl [int];
  logic [31:0] m_rd = 0, m_rc = 0, m_wc = 0;
  logic m_err = 0, m_v = 0;

  inst_sram #(.DEPTH(DEPTH), .ADDR_W(10), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .inst_sram_en(en), .inst_sram_wen(wen),
    .inst_sram_addr(addr), .inst_sram_write_data(wdata),
    .inst_sram_read_data(rdata), .inst_sram_rvalid(rvalid),
    .addr_err(err), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    return a[1:0] == 2'b00 && a < DEPTH * 4;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".rvalid"}, {31'b0, rvalid}, {31'b0, m_v});
    if (m_v) begin
      if (q.size() == 0) chk({tag, ".queue_empty"}, 32'd1, 32'd0);
      else m_rd = q.pop_front();
    end
    chk({tag, ".rdata"}, rdata, m_rd);
    chk({tag, ".addr_err"}, {31'b0, err}, {31'b0, m_err});
    chk({tag, ".rd_cnt"}, rd_cnt, m_rc);
    chk({tag, ".wr_cnt"}, wr_cnt, m_wc);
  endtask

  task automatic step(input string tag, input logic e, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    en = e; wen = w; addr = a; wdata = d;
    m_v = e && !w;
    if (e && !w) begin
      q.push_back(legal(a) ? mdl[int'(a >> 2)] : 32'h0);
      if (legal(a)) m_rc++;
    end
    if (e && w && legal(a)) begin
      mdl[int'(a >> 2)] = d;
      m_wc++;
    end
    if (e && !legal(a)) m_err = 1;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    #12;
    chk("reset.rdata", rdata, 32'h0);
    chk("reset.rvalid", {31'b0, rvalid}, 32'h0);
    chk("reset.addr_err", {31'b0, err}, 32'h0);
    chk("reset.rd_cnt", rd_cnt, 32'h0);
    chk("reset.wr_cnt", wr_cnt, 32'h0);
    @(negedge clk); rst = 1;
    step("wr10", 1, 1, 32'h10, 32'hDEADBEEF);
    step("rd10", 1, 0, 32'h10, 32'h0);
    chk("rd10.const", rdata, 32'hDEADBEEF);
    chk("rd10.cnt", rd_cnt + wr_cnt, 32'd2);
    for (int i = 0; i < 4; i++) step("pre", 1, 1, 32'(i * 4), 32'(i + 1));
    for (int i = 0; i < 4; i++) begin
      step("b2b", 1, 0, 32'(i * 4), 32'h0);
      chk("b2b.const", rdata, 32'(i + 1));
    end
    chk("b2b.rd_cnt", rd_cnt, 32'd5);
    step("misalign", 1, 0, 32'h2, 32'h0);
    chk("misalign.const", {rdata[30:0], err}, 32'h1);
    step("oor", 1, 0, DEPTH * 4, 32'h0);
    step("oor_wr", 1, 1, 32'hFFFF_FFF0, 32'h1234_5678);
    step("sticky", 1, 0, 32'h4, 32'h0);
    chk("sticky.const", {31'b0, err}, 32'h1);
    step("rd10b", 1, 0, 32'h10, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step("idle", 0, i[0], 32'h8, 32'hFFFF_FFFF);
      chk("idle.hold", rdata, 32'hDEADBEEF);
    end
    step("rd0", 1, 0, 32'h0, 32'h0);
    @(negedge clk);
    en = 1; wen = 0; addr = 32'h4;
    #2 rst = 0;
    #1;
    q.delete();
    m_v = 0; m_rd = 0; m_err = 0; m_rc = 0; m_wc = 0;
    @(posedge clk); #1;
    check_all("midrst");
    @(negedge clk); rst = 1; en = 0;
    step("post_rst", 1, 0, 32'h10, 32'h0);
    chk("post_rst.const", rdata, 32'hDEADBEEF);
    step("post_idle", 0, 0, 32'h0, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
